// File: rtl/fpu_pkg.sv
// fpu_pkg: op encodings and dispatcher state type shared by fpu_dispatch.
`default_nettype none
package fpu_pkg;

    localparam logic [1:0] OP_FADD   = 2'd0;
    localparam logic [1:0] OP_FSUB   = 2'd1;
    localparam logic [1:0] OP_FMUL   = 2'd2;
    localparam logic [1:0] OP_FDIV   = 2'd3;
    localparam int         NUM_UNITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic [NUM_UNITS-1:0] op_onehot(input logic [1:0] op);
        return NUM_UNITS'(1) << op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_dispatch.sv
// fpu_dispatch: issues one FP op at a time to the unit selected by req_op over
// split A/B streams, then returns the unit result or a timeout error.
`default_nettype none
module fpu_dispatch
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [31:0]             req_a,
    input  logic [31:0]             req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_data,
    output logic                    rsp_err,
    output logic [31:0]             a_tdata,
    output logic [NUM_UNITS-1:0]    a_tvalid,
    input  logic [NUM_UNITS-1:0]    a_tready,
    output logic [31:0]             b_tdata,
    output logic [NUM_UNITS-1:0]    b_tvalid,
    input  logic [NUM_UNITS-1:0]    b_tready,
    input  logic [32*NUM_UNITS-1:0] res_tdata,
    input  logic [NUM_UNITS-1:0]    res_tvalid,
    output logic [NUM_UNITS-1:0]    res_tready
);

    localparam int            CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [31:0]    a_q, a_d;
    logic [31:0]    b_q, b_d;
    logic           a_done_q, a_done_d;
    logic           b_done_q, b_done_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;

    logic [NUM_UNITS-1:0] sel;
    logic                 a_hs, b_hs, res_hs;
    logic [31:0]          res_slice;

    // Every handshake output is decoded from registers only, so an async reset
    // of state_q removes all valids/readies in the same cycle.
    always_comb begin
        sel        = op_onehot(op_q);
        a_tvalid   = (state_q == ST_ISSUE && !a_done_q) ? sel : '0;
        b_tvalid   = (state_q == ST_ISSUE && !b_done_q) ? sel : '0;
        res_tready = (state_q == ST_WAIT) ? sel : '0;
        req_ready  = (state_q == ST_IDLE);
        rsp_valid  = (state_q == ST_RESP);
        a_tdata    = a_q;
        b_tdata    = b_q;
        rsp_data   = rsp_data_q;
        rsp_err    = rsp_err_q;
        a_hs       = |(a_tvalid & a_tready);
        b_hs       = |(b_tvalid & b_tready);
        res_hs     = |(res_tready & res_tvalid);
        res_slice  = res_tdata[{op_q, 5'd0} +: 32];
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        a_done_d   = a_done_q;
        b_done_d   = b_done_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d     = req_op;
                    a_d      = req_a;
                    b_d      = req_b;
                    a_done_d = 1'b0;
                    b_done_d = 1'b0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                a_done_d = a_done_q | a_hs;
                b_done_d = b_done_q | b_hs;
                if (a_done_d && b_done_d) begin
                    a_done_d = 1'b0;
                    b_done_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A result landing on the final count still completes normally.
                if (res_hs) begin
                    rsp_data_d = res_slice;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (cnt_q == CNT_MAX) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_FADD;
            a_q        <= '0;
            b_q        <= '0;
            a_done_q   <= 1'b0;
            b_done_q   <= 1'b0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            a_done_q   <= a_done_d;
            b_done_q   <= b_done_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/fpu_dispatch.md
FPU_DISPATCH -- requirements
Module: fpu_dispatch

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, max cycles in WAIT before error completion.
REQ-002 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  in  1  requester offers op.
REQ-005 SHALL have port req_ready  out  1  dispatcher accepts op.
REQ-006 SHALL have port req_op  in  2  0=fadd 1=fsub 2=fmul 3=fdiv.
REQ-007 SHALL have port req_a  in  32  operand A.
REQ-008 SHALL have port req_b  in  32  operand B.
REQ-009 SHALL have port rsp_valid  out  1  result available.
REQ-010 SHALL have port rsp_ready  in  1  requester takes result.
REQ-011 SHALL have port rsp_data  out  32  result.
REQ-012 SHALL have port rsp_err  out  1  timeout completion.
REQ-013 SHALL have port a_tdata  out  32  A stream data, shared by all units.
REQ-014 SHALL have port a_tvalid / a_tready  out/in  4 each  per-unit A handshake, index = op.
REQ-015 SHALL have port b_tdata  out  32  B stream data, shared.
REQ-016 SHALL have port b_tvalid / b_tready  out/in  4 each  per-unit B handshake.
REQ-017 SHALL have port res_tdata  in  128  packed results, unit n at [32n+31:32n].
REQ-018 SHALL have port res_tvalid / res_tready  in/out  4 each  per-unit result handshake.

Function
REQ-019 SHALL run FSM IDLE, ISSUE, WAIT, RESP; one op in flight.
REQ-020 IDLE: req_ready=1; req_valid&req_ready latches op, A, B, next state ISSUE.
REQ-021 ISSUE: a_tvalid[op]=1 until first cycle a_tready[op]=1, b_tvalid[op]=1 until first cycle b_tready[op]=1, each tracked independently by done flags.
REQ-022 ISSUE->WAIT on the cycle both A and B handshakes are complete (incl. same cycle).
REQ-023 a_tdata/b_tdata SHALL hold latched operands stable while respective tvalid is high.
REQ-024 WAIT: res_tready[op]=1; res_tvalid[op]=1 captures res_tdata slice op into rsp_data, rsp_err=0, next RESP.
REQ-025 WAIT counter SHALL start at 0 on entry, increment each cycle; at count==TIMEOUT without res_tvalid, go RESP with rsp_data=0, rsp_err=1.
REQ-026 Result arrival in the same cycle as count==TIMEOUT SHALL win (normal completion).
REQ-027 RESP: rsp_valid=1, data/err stable until rsp_ready=1, then IDLE.
REQ-028 Minimum latency: accept cycle 0, ISSUE 1, WAIT 2; if res_tvalid at 2, rsp_valid at cycle 3.
REQ-029 All valid/ready bits of non-selected units SHALL be 0; their res_tvalid ignored.
REQ-030 req_ready SHALL be 0 outside IDLE; new req accepted cycle after RESP handshake.

Reset
REQ-031 On rst: state IDLE, req_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_data=0, all tvalid/tready=0, done flags and counter 0.
REQ-032 rst mid-operation SHALL drop all stream valids immediately (async), discarding the op.

Structure
REQ-033 Shared package fpu_pkg SHALL hold op encoding constants and FSM state type.
REQ-034 Single module, no sub-module.

Verification
REQ-035 fadd 0x3F800000+0x40000000, readies high, result 0x40400000 at cycle 2 -> rsp_data=0x40400000, rsp_valid cycle 3, err=0.
REQ-036 fmul, a_tready delayed 3 cycles, b_tready immediate -> b_tvalid one cycle only, a_tvalid 4 cycles, WAIT only after A accepted.
REQ-037 fdiv, res_tvalid never, TIMEOUT=15 -> rsp_valid with err=1, data=0 exactly 16 cycles after WAIT entry.
REQ-038 rsp_ready held 0 for 5 cycles -> rsp_data stable, req_ready=0, second req_valid not accepted until after handshake.
REQ-039 rst asserted in WAIT of fsub -> all tvalid/tready 0 same cycle, req_ready=1 after release, no rsp_valid.
REQ-040 res_tvalid[2] pulsed during fadd WAIT -> ignored, res_tready[2]=0, fadd result returned.
